// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory loads/stores over a req/gnt/rvalid bus, writeback select, branch redirect.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
package mem_access_pkg;
   typedef enum logic [1:0] {
      WB_SRC_ALU = 2'd0,
      WB_SRC_MEM = 2'd1,
      WB_SRC_PC4 = 2'd2,
      WB_SRC_IMM = 2'd3
   } wb_source_type;
endpackage

module mem_access_stage
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          clk_i,
   input  logic          rst,
   input  logic          flush_i,
   input  logic [4:0]    mem_rd_i,
   input  logic          mem_alu_zero_i,
   input  logic [31:0]   mem_alu_result_i,
   input  logic [31:0]   mem_pc_4_i,
   input  logic [31:0]   mem_pc_imm_i,
   input  logic [31:0]   mem_store_data_i,
   input  logic [1:0]    mem_size_i,
   input  logic          mem_unsigned_i,
   input  logic          mem_memwrite_en_i,
   input  logic          mem_memread_en_i,
   input  logic          mem_branch_i,
   input  logic          mem_jmp_i,
   input  logic          mem_wb_en_i,
   input  wb_source_type mem_wb_src_i,
   output logic          dmem_req_o,
   output logic          dmem_we_o,
   output logic [31:0]   dmem_addr_o,
   output logic [3:0]    dmem_be_o,
   output logic [31:0]   dmem_wdata_o,
   input  logic          dmem_gnt_i,
   input  logic          dmem_rvalid_i,
   input  logic [31:0]   dmem_rdata_i,
   output logic          stall_o,
   output logic [4:0]    wb_rd_o,
   output logic          wb_en_o,
   output logic [31:0]   wb_data_o,
   output logic          pc_redirect_o,
   output logic [31:0]   pc_target_o,
   output logic          misalign_o,
   output logic          bus_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state, state_next;
   logic [31:0] load_data_q, load_data_next;
   logic        kill_q, kill_next;
   logic        mem_op, misalign, aligned_op, timeout;

   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Shift the addressed lane down to bit 0, then extend to 32 bits.
   function automatic logic [31:0] format_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] a, input logic uns);
      logic [31:0]        shifted;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      shifted = rdata >> {a, 3'b000};
      b = shifted[7:0];
      h = shifted[15:0];
      case (size)
         2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: return shifted;
      endcase
   endfunction

   assign mem_op     = mem_memread_en_i | mem_memwrite_en_i;
   assign misalign   = mem_op & (((mem_size_i == 2'b01) & mem_alu_result_i[0]) |
                                 (mem_size_i[1] & (mem_alu_result_i[1:0] != 2'b00)));
   assign aligned_op = mem_op & ~misalign & ~flush_i;
   assign misalign_o = misalign & ~flush_i;

   assign dmem_we_o    = mem_memwrite_en_i;
   assign dmem_addr_o  = {mem_alu_result_i[31:2], 2'b00};
   assign dmem_be_o    = byte_enables(mem_size_i, mem_alu_result_i[1:0]);
   assign dmem_wdata_o = replicate_store(mem_size_i, mem_store_data_i);

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state       <= IDLE;
         load_data_q <= '0;
         kill_q      <= 1'b0;
      end else begin
         state       <= state_next;
         load_data_q <= load_data_next;
         kill_q      <= kill_next;
      end
   end

   always_comb begin
      state_next     = state;
      load_data_next = load_data_q;
      kill_next      = kill_q;
      dmem_req_o     = 1'b0;
      stall_o        = 1'b0;
      unique case (state)
         IDLE: begin
            if (aligned_op) begin
               dmem_req_o = 1'b1;
               stall_o    = 1'b1;
               if (dmem_gnt_i) state_next = mem_memwrite_en_i ? DONE : RESP;
               else            state_next = REQ;
            end
         end
         REQ: begin
            // Withdrawal is only legal here, before the slave has granted.
            if (flush_i) begin
               state_next = IDLE;
            end else begin
               dmem_req_o = 1'b1;
               stall_o    = 1'b1;
               if (dmem_gnt_i) begin
                  state_next = mem_memwrite_en_i ? DONE : RESP;
               end else if (timeout) begin
                  state_next     = DONE;
                  load_data_next = '0;
               end
            end
         end
         RESP: begin
            stall_o = 1'b1;
            if (dmem_rvalid_i) begin
               kill_next = 1'b0;
               if (kill_q | flush_i) begin
                  state_next = IDLE;
               end else begin
                  state_next     = DONE;
                  load_data_next = format_load(dmem_rdata_i, mem_size_i,
                                               mem_alu_result_i[1:0], mem_unsigned_i);
               end
            end else if (timeout) begin
               kill_next      = 1'b0;
               load_data_next = '0;
               state_next     = (kill_q | flush_i) ? IDLE : DONE;
            end else if (flush_i) begin
               kill_next = 1'b1;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   logic [15:0] watchdog;
   logic        in_wait, stay_wait;

   assign in_wait   = (state == REQ) || (state == RESP);
   assign stay_wait = (state_next == REQ) || (state_next == RESP);
   assign timeout   = in_wait && (watchdog == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst) begin
         watchdog  <= '0;
         bus_err_o <= 1'b0;
      end else begin
         watchdog  <= (in_wait && stay_wait) ? watchdog + 16'd1 : 16'd0;
         bus_err_o <= timeout && (((state == REQ) && !flush_i && !dmem_gnt_i) ||
                                  ((state == RESP) && !dmem_rvalid_i));
      end
   end
`else
   assign timeout   = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   always_comb begin
      case (mem_wb_src_i)
         WB_SRC_MEM: wb_data_o = load_data_q;
         WB_SRC_PC4: wb_data_o = mem_pc_4_i;
         default:    wb_data_o = mem_alu_result_i;
      endcase
   end

   assign wb_rd_o       = mem_rd_i;
   assign wb_en_o       = mem_wb_en_i & ~flush_i & ~misalign &
                          ~(mem_memread_en_i && (state != DONE));
   assign pc_redirect_o = ~flush_i & (mem_jmp_i | (mem_branch_i & mem_alu_zero_i));
   assign pc_target_o   = mem_pc_imm_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, flush, redirect and,
// when MEM_TIMEOUT_EN is defined, the bus watchdog.
module tb_mem_access_stage;
   import mem_access_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [4:0]    rd;
   logic          alu_zero;
   logic [31:0]   alu_result, pc_4, pc_imm, store_data;
   logic [1:0]    size;
   logic          is_unsigned, memwrite, memread, branch, jmp, wb_en_in;
   wb_source_type wb_src;
   logic          req, we, gnt, rvalid;
   logic [31:0]   addr, wdata, rdata;
   logic [3:0]    be;
   logic          stall, wb_en, redirect, misalign, bus_err;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data, target;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
   mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
`else
   mem_access_stage dut (
`endif
      .clk_i(clk), .rst(rst), .flush_i(flush), .mem_rd_i(rd), .mem_alu_zero_i(alu_zero),
      .mem_alu_result_i(alu_result), .mem_pc_4_i(pc_4), .mem_pc_imm_i(pc_imm),
      .mem_store_data_i(store_data), .mem_size_i(size), .mem_unsigned_i(is_unsigned),
      .mem_memwrite_en_i(memwrite), .mem_memread_en_i(memread), .mem_branch_i(branch),
      .mem_jmp_i(jmp), .mem_wb_en_i(wb_en_in), .mem_wb_src_i(wb_src),
      .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
      .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
      .stall_o(stall), .wb_rd_o(wb_rd), .wb_en_o(wb_en), .wb_data_o(wb_data),
      .pc_redirect_o(redirect), .pc_target_o(target), .misalign_o(misalign), .bus_err_o(bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; rd = 5'd0; alu_zero = 0; alu_result = 32'd0; pc_4 = 32'd0; pc_imm = 32'd0;
      store_data = 32'd0; size = 2'b10; is_unsigned = 0; memwrite = 0; memread = 0;
      branch = 0; jmp = 0; wb_en_in = 0; wb_src = WB_SRC_ALU; gnt = 0; rvalid = 0; rdata = 32'd0;
   endtask

   task automatic start_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
      idle_inputs();
      memread = 1; alu_result = a; size = sz; is_unsigned = uns;
      wb_en_in = 1; wb_src = WB_SRC_MEM; rd = 5'd7; gnt = 1;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick(); tick(); #4;
      chk("reset_req", req, 0);
      chk("reset_stall", stall, 0);
      chk("reset_misalign", misalign, 0);
      chk("reset_bus_err", bus_err, 0);
      tick(); rst = 0;

      // Word load 0x100, gnt at once, rvalid one cycle later.
      start_load(32'h100, 2'b10, 0); #4;
      chk("wl_req", req, 1); chk("wl_stall0", stall, 1); chk("wl_addr", addr, 32'h100);
      chk("wl_be", be, 4'hF); chk("wl_we", we, 0); chk("wl_wben0", wb_en, 0);
      tick(); gnt = 0; rvalid = 1; rdata = 32'hCAFEBABE; #4;
      chk("wl_stall1", stall, 1); chk("wl_req1", req, 0); chk("wl_wben1", wb_en, 0);
      tick(); rvalid = 0; #4;
      chk("wl_stall2", stall, 0); chk("wl_wben2", wb_en, 1);
      chk("wl_data", wb_data, 32'hCAFEBABE); chk("wl_rd", wb_rd, 5'd7); chk("wl_req2", req, 0);
      tick(); idle_inputs(); #4;
      chk("wl_after_stall", stall, 0);

      // Signed byte load at 0x103.
      start_load(32'h103, 2'b00, 0); #4;
      chk("sb_be", be, 4'b1000); chk("sb_addr", addr, 32'h100);
      tick(); gnt = 0; rvalid = 1; rdata = 32'h80112233;
      tick(); rvalid = 0; #4;
      chk("sb_data", wb_data, 32'hFFFFFF80);
      tick(); idle_inputs();

      // Unsigned byte load at 0x103.
      start_load(32'h103, 2'b00, 1);
      tick(); gnt = 0; rvalid = 1; rdata = 32'h80112233;
      tick(); rvalid = 0; #4;
      chk("ub_data", wb_data, 32'h00000080);
      tick(); idle_inputs();

      // Half store 0x202, grant withheld for three cycles.
      memwrite = 1; size = 2'b01; alu_result = 32'h202; store_data = 32'h0000ABCD; #4;
      chk("hs_req0", req, 1); chk("hs_be", be, 4'b1100); chk("hs_wdata", wdata, 32'hABCDABCD);
      chk("hs_addr", addr, 32'h200); chk("hs_we", we, 1); chk("hs_stall0", stall, 1);
      tick(); #4; chk("hs_req1", req, 1);
      tick(); #4; chk("hs_req2", req, 1); chk("hs_stall2", stall, 1);
      tick(); gnt = 1; #4; chk("hs_req3", req, 1);
      tick(); gnt = 0; #4;
      chk("hs_done_req", req, 0); chk("hs_done_stall", stall, 0);
      tick(); idle_inputs(); #4;
      chk("hs_idle_req", req, 0);

      // Non-memory pass-through.
      wb_en_in = 1; alu_result = 32'h00001234; pc_4 = 32'h00000804; #4;
      chk("alu_data", wb_data, 32'h00001234); chk("alu_wben", wb_en, 1); chk("alu_stall", stall, 0);
      wb_src = WB_SRC_PC4; #1;
      chk("pc4_data", wb_data, 32'h00000804);
      tick(); idle_inputs();

      // Misaligned word load and half store.
      memread = 1; wb_en_in = 1; alu_result = 32'h105; size = 2'b10; gnt = 1; #4;
      chk("mis_flag", misalign, 1); chk("mis_req", req, 0);
      chk("mis_stall", stall, 0); chk("mis_wben", wb_en, 0);
      tick(); idle_inputs(); memwrite = 1; size = 2'b01; alu_result = 32'h201; #4;
      chk("mis_half_flag", misalign, 1); chk("mis_half_req", req, 0);
      flush = 1; #1;
      chk("mis_flushed", misalign, 0);
      tick(); idle_inputs();

      // Flush while waiting for read data; the returned data must be dropped.
      start_load(32'h300, 2'b10, 0);
      tick(); gnt = 0; flush = 1; #4;
      chk("fl_stall", stall, 1); chk("fl_wben", wb_en, 0); chk("fl_req", req, 0);
      tick(); flush = 0; rvalid = 1; rdata = 32'hDEADBEEF; #4;
      chk("fl_rv_wben", wb_en, 0); chk("fl_rv_stall", stall, 1);
      tick(); idle_inputs(); wb_en_in = 1; wb_src = WB_SRC_MEM; #4;
      chk("fl_idle_stall", stall, 0); chk("fl_idle_req", req, 0);
      chk("fl_keep_data", wb_data, 32'h00000080);

      // Branch/jump redirect.
      branch = 1; alu_zero = 1; pc_imm = 32'h40; #4;
      chk("br_taken", redirect, 1); chk("br_target", target, 32'h40);
      flush = 1; #1; chk("br_flushed", redirect, 0);
      flush = 0; alu_zero = 0; #1; chk("br_not_taken", redirect, 0);
      branch = 0; jmp = 1; #1; chk("jmp_taken", redirect, 1);
      tick(); idle_inputs();

`ifdef MEM_TIMEOUT_EN
      // Grant never arrives: error pulse after eight REQ cycles, then DONE with zeroed data.
      start_load(32'h400, 2'b10, 0); gnt = 0; #4;
      chk("to_req_idle", req, 1);
      for (int i = 0; i < 8; i++) begin
         tick(); #4;
         chk("to_req_wait", req, 1);
         chk("to_no_err", bus_err, 0);
      end
      tick(); #4;
      chk("to_bus_err", bus_err, 1); chk("to_stall", stall, 0);
      chk("to_data", wb_data, 32'h0); chk("to_req_done", req, 0);
      tick(); idle_inputs(); #4;
      chk("to_err_pulse", bus_err, 0);
`else
      // Without the watchdog the FSM just keeps requesting.
      start_load(32'h400, 2'b10, 0); gnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
      end
      #4;
      chk("nto_req", req, 1); chk("nto_bus_err", bus_err, 0); chk("nto_stall", stall, 1);
      tick(); gnt = 1;
      tick(); gnt = 0; rvalid = 1; rdata = 32'h12345678;
      tick(); rvalid = 0; #4;
      chk("nto_data", wb_data, 32'h12345678);
      tick(); idle_inputs();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage: consumes EX/MEM pipeline-register outputs and performs data-memory loads and stores over a req/gnt/rvalid bus.
- Formats load data and selects the writeback value for the MEM/WB register.
- Resolves branch/jump redirect.
- Raises stall_o to freeze upstream registers while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, bus watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  kill current MEM-stage op.
- mem_rd_i  in  5  destination register.
- mem_alu_zero_i  in  1  branch compare result.
- mem_alu_result_i  in  32  ALU result / memory address.
- mem_pc_4_i  in  32  PC+4.
- mem_pc_imm_i  in  32  branch/jump target.
- mem_store_data_i  in  32  rs2 store data.
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
- mem_unsigned_i  in  1  zero-extend loads.
- mem_memwrite_en_i, mem_memread_en_i, mem_branch_i, mem_jmp_i, mem_wb_en_i  in  1 each  control.
- mem_wb_src_i  in  wb_source_type  writeback source.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read data.
- stall_o  out  1  freeze IF..EX/MEM.
- wb_rd_o  out  5  to MEM/WB.
- wb_en_o  out  1  to MEM/WB.
- wb_data_o  out  32  to MEM/WB.
- pc_redirect_o  out  1  take branch/jump.
- pc_target_o  out  32  redirect target.
- misalign_o  out  1  misaligned access pulse.
- bus_err_o  out  1  watchdog expiry pulse.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, load_data_q=0, kill_q=0, watchdog=0.
  - dmem_req_o=0, stall_o=0, misalign_o=0, bus_err_o=0.
  - Reset mid-transaction abandons the access; the bus slave is reset by the same rst.
- mem_op = memread|memwrite.
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=0.
- Misaligned op, unflushed: misalign_o=1 combinationally, no request issued, stall_o=0, wb_en_o=0.
- Byte enables from size and addr[1:0]: byte 0001<<a; half 0011<<a; word 1111.
- Store data replication: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE, aligned mem_op, !flush_i:
    - dmem_req_o=1 this cycle; stall_o=1.
    - gnt: store goes to DONE, load goes to RESP.
    - No gnt: go to REQ.
  - REQ:
    - req held; addr/we/be/wdata stable from inputs, which the upstream stall keeps stable.
    - gnt: same transitions as IDLE.
    - flush_i without gnt: drop req, go to IDLE. A request may be withdrawn only before gnt.
  - RESP:
    - req=0, stall_o=1.
    - On rvalid: load_data_q = lane-shifted rdata, sign- or zero-extended per size/unsigned; go to DONE.
    - flush_i in RESP sets kill_q. rvalid with kill_q set returns to IDLE, discards data, clears kill_q.
  - DONE:
    - stall_o=0, req=0; always go to IDLE next cycle.
    - Does not re-issue, even though inputs still hold the same op this cycle.
- Latency: zero-wait store 2 cycles (1 stall). Zero-wait load with rvalid one cycle after gnt: 3 cycles (2 stall).
- Non-memory ops: stall_o=0, pure pass-through, no state change.
- wb_data_o selection (combinational):
  - WB_SRC_MEM: load_data_q.
  - WB_SRC_PC4: mem_pc_4_i.
  - Otherwise: mem_alu_result_i.
- wb_en_o = mem_wb_en_i & !flush_i & !misalign & !(load && state!=DONE).
- wb_rd_o = mem_rd_i.
- pc_redirect_o = !flush_i & (mem_jmp_i | (mem_branch_i & mem_alu_zero_i)); pc_target_o = mem_pc_imm_i.
- Simultaneous gnt and rvalid in the same cycle is illegal; rvalid arrives no earlier than 1 cycle after gnt.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 16-bit watchdog counts cycles in REQ or RESP and clears on leaving them.
  - At TIMEOUT_CYCLES: bus_err_o=1 for one cycle, load_data_q=0, go to DONE.
- MEM_TIMEOUT_EN undefined: no counter, bus_err_o tied 0, FSM waits indefinitely.

Test Plan:
- Word load addr 0x100, gnt same cycle, rvalid next cycle, rdata 0xCAFEBABE -> stall_o 1,1,0; wb_data_o=0xCAFEBABE in DONE; wb_en_o=1 only in DONE.
- Signed byte load addr 0x103, rdata 0x80112233 -> be=1000, wb_data_o=0xFFFFFF80; unsigned variant -> 0x00000080.
- Half store addr 0x202, data 0x0000ABCD, gnt delayed 3 cycles -> req held 4 cycles, be=1100, wdata=0xABCDABCD, addr 0x200, then DONE.
- Word load addr 0x105 -> misalign_o=1, dmem_req_o=0, stall_o=0, wb_en_o=0.
- Flush in RESP then rvalid -> FSM to IDLE, load_data_q unchanged, wb_en_o=0; branch=1, zero=1, pc_imm 0x40 -> pc_redirect_o=1, pc_target_o=0x40.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never asserted -> bus_err_o pulses after 8 REQ cycles, then DONE with wb_data_o=0.
